// File: rtl/fft64_pkg.sv
// Shared types, limits and saturation helper for the 64-point SDF FFT.
package fft64_pkg;

   localparam int LOG_N = 6;
   localparam int WIDTH = 16;

   localparam logic [WIDTH-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [WIDTH-1:0] SAT_MIN = 16'h8000;

   typedef struct packed {
      logic signed [WIDTH-1:0] re;
      logic signed [WIDTH-1:0] im;
   } cplx_t;

   // Drop the 15 fraction bits and clamp to the Q1.15 range.
   function automatic logic [WIDTH-1:0] saturate(
      input logic signed [32:0] x
   );
      logic signed [17:0] t;
      t = x[32:15];
      if (t > 18'sd32767) begin
         return SAT_MAX;
      end else if (t < -18'sd32768) begin
         return SAT_MIN;
      end else begin
         return t[WIDTH-1:0];
      end
   endfunction

endpackage

// File: rtl/cmul16.sv
// Two-register Q1.15 complex multiplier: products, then sum/round/saturate.
// Define TWMUL_ROUND_EN for round-half-up; otherwise results truncate.
module cmul16
   import fft64_pkg::*;
(
   input  logic  clock,
   input  logic  reset,
   input  cplx_t a,
   input  cplx_t b,
   output cplx_t p
);

   logic signed [31:0] ac_q, ac_d;
   logic signed [31:0] bd_q, bd_d;
   logic signed [31:0] ad_q, ad_d;
   logic signed [31:0] bc_q, bc_d;
   logic signed [32:0] re_sum;
   logic signed [32:0] im_sum;
   cplx_t              p_q, p_d;

   always_comb begin
      ac_d = a.re * b.re;
      bd_d = a.im * b.im;
      ad_d = a.re * b.im;
      bc_d = a.im * b.re;
      re_sum = 33'(ac_q) - 33'(bd_q);
      im_sum = 33'(ad_q) + 33'(bc_q);
`ifdef TWMUL_ROUND_EN
      re_sum = re_sum + 33'sd16384;
      im_sum = im_sum + 33'sd16384;
`else
      re_sum = re_sum;
      im_sum = im_sum;
`endif
      p_d.re = saturate(re_sum);
      p_d.im = saturate(im_sum);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ac_q <= '0;
         bd_q <= '0;
         ad_q <= '0;
         bc_q <= '0;
         p_q  <= '0;
      end else begin
         ac_q <= ac_d;
         bd_q <= bd_d;
         ad_q <= ad_d;
         bc_q <= bc_d;
         p_q  <= p_d;
      end
   end

   assign p = p_q;

endmodule

// File: rtl/twiddle_mult64.sv
// Twiddle-multiply stage after BF2II: address generation, stage-1
// alignment and unity bypass around cmul16 (TWMUL_ROUND_EN in cmul16).
module twiddle_mult64 #(
   parameter int WIDTH = 16,
   parameter int LOG_M = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             di_en,
   input  logic [WIDTH-1:0] di_re,
   input  logic [WIDTH-1:0] di_im,
   output logic [5:0]       tw_addr,
   input  logic [WIDTH-1:0] tw_re,
   input  logic [WIDTH-1:0] tw_im,
   output logic             do_en,
   output logic [WIDTH-1:0] do_re,
   output logic [WIDTH-1:0] do_im
);
   import fft64_pkg::*;

   typedef struct packed {
      logic  en;
      logic  byp;
      cplx_t x;
   } stage_t;

   logic [LOG_M-1:0] di_count_q, di_count_d;
   logic [1:0]       tw_sel;
   logic [5:0]       tw_num;
   stage_t           s1_q, s1_d;
   stage_t           s2_q, s2_d;
   stage_t           s3_q, s3_d;
   cplx_t            tw;
   cplx_t            prod;

   always_comb begin
      di_count_d = di_en ? di_count_q + LOG_M'(1) : di_count_q;
      tw_sel = {di_count_q[LOG_M-2], di_count_q[LOG_M-1]};
      tw_num = 6'(di_count_q[LOG_M-3:0]) << (6 - LOG_M);
      tw_addr = 6'(tw_num * 6'(tw_sel));
      s1_d.en = di_en;
      s1_d.byp = (tw_addr == 6'd0);
      s1_d.x.re = di_re;
      s1_d.x.im = di_im;
      // Bypassed samples ride alongside the multiplier pipeline.
      s2_d = s1_q;
      s3_d = s2_q;
      tw.re = tw_re;
      tw.im = tw_im;
      do_en = s3_q.en;
      do_re = s3_q.byp ? s3_q.x.re : prod.re;
      do_im = s3_q.byp ? s3_q.x.im : prod.im;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         di_count_q <= '0;
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         di_count_q <= di_count_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   cmul16 u_cmul (
      .clock (clock),
      .reset (reset),
      .a     (s1_q.x),
      .b     (tw),
      .p     (prod)
   );

endmodule
